// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command responder and the command generator:
// command bus encodings, FSM state encodings and bus geometry.
// -----------------------------------------------------------------------------
package cmd_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 16;

    // Command bus encodings; any code not listed here is invalid.
    typedef enum logic [2:0] {
        CMD_NOP = 3'b111,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b101,
        CMD_RD  = 3'b110
    } cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

endpackage

// File: rtl/cmd_responder_if.sv
// -----------------------------------------------------------------------------
// cmd_responder_if
// Command/response bundle between a command generator (master) and the
// responder (slave).
//   cmd, addr, wdata, err_clr          : master -> slave
//   rdata, rd_valid, wr_ack, proto_err,
//   err_sticky, wr_cnt, rd_cnt         : slave -> master
// cmd is a plain 3-bit vector so that invalid codes can be carried.
// -----------------------------------------------------------------------------
interface cmd_responder_if;
    import cmd_pkg::*;

    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              err_clr;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic              wr_ack;
    logic              proto_err;
    logic              err_sticky;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;

    modport master (
        output cmd, addr, wdata, err_clr,
        input  rdata, rd_valid, wr_ack, proto_err, err_sticky, wr_cnt, rd_cnt
    );

    modport slave (
        input  cmd, addr, wdata, err_clr,
        output rdata, rd_valid, wr_ack, proto_err, err_sticky, wr_cnt, rd_cnt
    );

endinterface

// File: rtl/cmd_regfile.sv
// -----------------------------------------------------------------------------
// cmd_regfile
// 16x8 storage with one synchronous write port and one registered read port.
// rdata holds its value until the next read. rst (async, active-low) clears
// every word and the read register.
//   clk, rst          : clock / async active-low clear
//   we, waddr, wdata  : write port
//   re, raddr, rdata  : registered read port
// -----------------------------------------------------------------------------
module cmd_regfile
    import cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/cmd_responder.sv
// -----------------------------------------------------------------------------
// cmd_responder
// Two-state (IDLE/ARMED) command responder. ACT arms the block with an
// address; a following WR or RD performs the access and returns to IDLE.
// Any other command sequence is a protocol violation. All outputs are
// registered: wr_ack / rd_valid / proto_err pulse in the cycle after the
// edge that caused them.
//   clk, rst : clock / async active-low reset
//   bus      : slave side of cmd_responder_if (commands in, responses out)
// -----------------------------------------------------------------------------
module cmd_responder
    import cmd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cmd_responder_if.slave  bus
);

    state_e            state;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_ack_q;
    logic              rd_valid_q;
    logic              proto_err_q;
    logic              err_sticky_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [DATA_W-1:0] rdata_w;

    logic do_wr;
    logic do_rd;
    logic viol;

    // Decode the command against the current state. In ARMED, everything
    // other than WR/RD (including a re-ACT) counts as a violation.
    always_comb begin
        do_wr = 1'b0;
        do_rd = 1'b0;
        viol  = 1'b0;
        case (state)
            ST_IDLE: begin
                viol = (bus.cmd != CMD_NOP) && (bus.cmd != CMD_ACT);
            end
            ST_ARMED: begin
                do_wr = (bus.cmd == CMD_WR);
                do_rd = (bus.cmd == CMD_RD);
                viol  = !(do_wr || do_rd);
            end
            default: ;
        endcase
    end

    // Memory writes and reads happen on the accepting edge; the read data
    // is therefore ready in the same cycle the rd_valid pulse appears.
    cmd_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (do_wr),
        .waddr (addr_q),
        .wdata (bus.wdata),
        .re    (do_rd),
        .raddr (addr_q),
        .rdata (rdata_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            wr_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
        end else begin
            wr_ack_q    <= do_wr;
            rd_valid_q  <= do_rd;
            proto_err_q <= viol;
            // A new violation wins over a simultaneous clear.
            err_sticky_q <= viol | (err_sticky_q & ~bus.err_clr);
            // Counters advance together with their pulse.
            if (do_wr) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
            if (do_rd) begin
                rd_cnt_q <= rd_cnt_q + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.cmd == CMD_ACT) begin
                        addr_q <= bus.addr;
                        state  <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Re-ACT restarts with the new address; anything else ends
                    // the transaction (completed or discarded).
                    if (bus.cmd == CMD_ACT) begin
                        addr_q <= bus.addr;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rdata      = rdata_w;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.proto_err  = proto_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.wr_cnt     = wr_cnt_q;
    assign bus.rd_cnt     = rd_cnt_q;

endmodule

// File: tb/tb_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_cmd_responder
// Scoreboard bench for cmd_responder. The driver keeps a transaction-level
// model (memory array, armed flag, pending address) and pushes the expected
// pulse cycle / read data into queues; an independent monitor pops them
// whenever the DUT raises rd_valid, wr_ack or proto_err.
// -----------------------------------------------------------------------------
module tb_cmd_responder;
    import cmd_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmd_responder_if bus();

    cmd_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level reference state
    logic [7:0] m_mem [16];
    bit         m_armed;
    logic [3:0] m_addr;
    bit         m_sticky;
    int         m_wr;
    int         m_rd;

    exp_t rd_q [$];
    int   wr_q [$];
    int   err_q [$];

    logic [7:0] hold_val = 8'h00;
    int         err_seen = 0;
    exp_t       mon_e;
    int         mon_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_armed  = 0;
        m_addr   = 4'h0;
        m_sticky = 0;
        m_wr     = 0;
        m_rd     = 0;
        hold_val = 8'h00;
    endtask

    // Called at a falling edge; the command is sampled on the next rising edge.
    task automatic issue(input logic [2:0] c, input logic [3:0] a, input logic [7:0] d, input bit clr);
        bit   v;
        exp_t e;
        v = 0;
        bus.cmd     = c;
        bus.addr    = a;
        bus.wdata   = d;
        bus.err_clr = clr;
        if (!m_armed) begin
            if (c == CMD_ACT) begin
                m_armed = 1;
                m_addr  = a;
            end else if (c != CMD_NOP) begin
                v = 1;
            end
        end else begin
            if (c == CMD_WR) begin
                m_mem[m_addr] = d;
                m_wr++;
                wr_q.push_back(cyc + 1);
                m_armed = 0;
            end else if (c == CMD_RD) begin
                e.cyc  = cyc + 1;
                e.data = m_mem[m_addr];
                rd_q.push_back(e);
                m_rd++;
                m_armed = 0;
            end else if (c == CMD_ACT) begin
                v = 1;
                m_addr = a;
            end else begin
                v = 1;
                m_armed = 0;
            end
        end
        if (v) err_q.push_back(cyc + 1);
        m_sticky = v | (m_sticky & !clr);
        @(negedge clk);
        chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
    endtask

    task automatic drain(input int n);
        repeat (n) issue(CMD_NOP, 4'h0, 8'h00, 1'b0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_wr_cnt"}, 32'(bus.wr_cnt), m_wr % 256);
        chk({tag, "_rd_cnt"}, 32'(bus.rd_cnt), m_rd % 256);
    endtask

    // Monitor: every pulse must match the head of its queue, on the right cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_valid_unexpected: rd_valid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    mon_e = rd_q.pop_front();
                    chk("rd_valid_cycle", cyc, mon_e.cyc);
                    chk("rdata", 32'(bus.rdata), 32'(mon_e.data));
                    hold_val = mon_e.data;
                end
            end else begin
                chk("rdata_hold", 32'(bus.rdata), 32'(hold_val));
            end
            if (bus.wr_ack) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_ack_unexpected: wr_ack=1 at cycle %0d, expected 0", cyc);
                end else begin
                    mon_c = wr_q.pop_front();
                    chk("wr_ack_cycle", cyc, mon_c);
                end
            end
            if (bus.proto_err) begin
                err_seen++;
                if (err_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL proto_err_unexpected: proto_err=1 at cycle %0d, expected 0", cyc);
                end else begin
                    mon_c = err_q.pop_front();
                    chk("proto_err_cycle", cyc, mon_c);
                end
            end
            if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                mon_e = rd_q.pop_front();
                checks++; errors++;
                $display("FAIL rd_valid_missing: no pulse at cycle %0d, expected one", mon_e.cyc);
            end
            if (wr_q.size() > 0 && wr_q[0] < cyc) begin
                mon_c = wr_q.pop_front();
                checks++; errors++;
                $display("FAIL wr_ack_missing: no pulse at cycle %0d, expected one", mon_c);
            end
            if (err_q.size() > 0 && err_q[0] < cyc) begin
                mon_c = err_q.pop_front();
                checks++; errors++;
                $display("FAIL proto_err_missing: no pulse at cycle %0d, expected one", mon_c);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int         e0;
        logic [2:0] inv_codes [4];
        logic [2:0] c;
        int         r;
        inv_codes[0] = 3'b000;
        inv_codes[1] = 3'b001;
        inv_codes[2] = 3'b010;
        inv_codes[3] = 3'b100;

        bus.cmd     = CMD_NOP;
        bus.addr    = 4'h0;
        bus.wdata   = 8'h00;
        bus.err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rdata",      32'(bus.rdata), 0);
        chk("rst_rd_valid",   32'(bus.rd_valid), 0);
        chk("rst_wr_ack",     32'(bus.wr_ack), 0);
        chk("rst_proto_err",  32'(bus.proto_err), 0);
        chk("rst_err_sticky", 32'(bus.err_sticky), 0);
        chk("rst_wr_cnt",     32'(bus.wr_cnt), 0);
        chk("rst_rd_cnt",     32'(bus.rd_cnt), 0);
        rst = 1'b1;

        // Write then read
        issue(CMD_ACT, 4'h3, 8'h00, 0);
        issue(CMD_WR,  4'h0, 8'hA5, 0);
        issue(CMD_NOP, 4'h0, 8'h00, 0);
        issue(CMD_ACT, 4'h3, 8'h00, 0);
        issue(CMD_RD,  4'h0, 8'h00, 0);
        drain(2);
        chk("wr_rd_wr_cnt", 32'(bus.wr_cnt), 1);
        chk("wr_rd_rd_cnt", 32'(bus.rd_cnt), 1);

        // Back-to-back transactions, no NOP between
        issue(CMD_ACT, 4'h2, 8'h00, 0);
        issue(CMD_WR,  4'h0, 8'h11, 0);
        issue(CMD_ACT, 4'h5, 8'h00, 0);
        issue(CMD_WR,  4'h0, 8'h22, 0);
        issue(CMD_ACT, 4'h2, 8'h00, 0);
        issue(CMD_RD,  4'h0, 8'h00, 0);
        issue(CMD_ACT, 4'h5, 8'h00, 0);
        issue(CMD_RD,  4'h0, 8'h00, 0);
        drain(2);
        check_counts("b2b");

        // Violations; seed mem[7] so the final read is distinguishable
        issue(CMD_ACT, 4'h7, 8'h00, 0);
        issue(CMD_WR,  4'h0, 8'h77, 0);
        drain(1);
        e0 = err_seen;
        issue(CMD_WR,  4'h0, 8'hEE, 0);
        issue(CMD_ACT, 4'h1, 8'h00, 0);
        issue(CMD_NOP, 4'h0, 8'h00, 0);
        issue(CMD_ACT, 4'h1, 8'h00, 0);
        issue(CMD_ACT, 4'h7, 8'h00, 0);
        issue(CMD_RD,  4'h0, 8'h00, 0);
        issue(3'b000,  4'h0, 8'h00, 0);
        drain(2);
        chk("viol_pulse_count", err_seen - e0, 4);
        chk("viol_sticky_set", 32'(bus.err_sticky), 1);
        issue(CMD_NOP, 4'h0, 8'h00, 1);
        chk("viol_sticky_clr", 32'(bus.err_sticky), 0);

        // Error coincident with clear: set wins (from clear and from set state)
        issue(3'b010, 4'h0, 8'h00, 1);
        chk("prio_from_clear", 32'(bus.err_sticky), 1);
        issue(CMD_RD, 4'h0, 8'h00, 1);
        chk("prio_from_set", 32'(bus.err_sticky), 1);
        drain(2);
        check_counts("pre_rst");

        // Reset while armed, with WR presented on the aborted edge
        issue(CMD_ACT, 4'h9, 8'h00, 0);
        bus.cmd   = CMD_WR;
        bus.wdata = 8'hFF;
        #2 rst = 1'b0;
        #1;
        chk("async_wr_cnt", 32'(bus.wr_cnt), 0);
        chk("async_rd_cnt", 32'(bus.rd_cnt), 0);
        chk("async_rdata",  32'(bus.rdata), 0);
        chk("async_sticky", 32'(bus.err_sticky), 0);
        repeat (2) @(negedge clk);
        chk("rst_pending_rd", rd_q.size(), 0);
        chk("rst_pending_wr", wr_q.size(), 0);
        model_reset();
        bus.cmd = CMD_NOP;
        rst = 1'b1;
        issue(CMD_ACT, 4'h9, 8'h00, 0);
        issue(CMD_RD,  4'h0, 8'h00, 0);
        drain(2);
        chk("midrst_wr_cnt", 32'(bus.wr_cnt), 0);
        check_counts("midrst");

        // Counter wrap: 256 writes
        for (int i = 0; i < 256; i++) begin
            issue(CMD_ACT, 4'($urandom_range(0, 15)), 8'h00, 0);
            issue(CMD_WR,  4'h0, 8'($urandom_range(0, 255)), 0);
        end
        drain(2);
        chk("wrap_wr_cnt", 32'(bus.wr_cnt), 0);
        check_counts("wrap");

        // Random command stream
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      c = CMD_NOP;
            else if (r < 5) c = CMD_ACT;
            else if (r < 7) c = CMD_WR;
            else if (r < 9) c = CMD_RD;
            else            c = inv_codes[$urandom_range(0, 3)];
            issue(c, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
            if (i % 250 == 249) begin
                drain(2);
                check_counts("rand");
            end
        end

        drain(3);
        check_counts("final");
        chk("final_rd_q_empty",  rd_q.size(), 0);
        chk("final_wr_q_empty",  wr_q.size(), 0);
        chk("final_err_q_empty", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
